front_end: RTL

FRONT_END -- requirements
Module: front_end

---
 rtl/copr_stream_pkg.sv | 4 +
 rtl/fe_skid_buf.sv | 68 ++++++
 rtl/front_end.sv | 71 +++++++
 3 files changed

// File: rtl/copr_stream_pkg.sv
// copr_stream_pkg: stream FSM encodings shared by front_end and back_end.
package copr_stream_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} stream_state_e;
endpackage

// File: rtl/fe_skid_buf.sv
// fe_skid_buf: token buffer between FSL and actor; 2 entries with FRONT_END_SKID_EN, else 1.
module fe_skid_buf #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
`ifdef FRONT_END_SKID_EN
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wp_q, wp_d, rp_q, rp_d;
   logic [1:0]   cnt_q, cnt_d;
   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      if (push) begin
         mem_d[wp_q] = din;
         wp_d        = ~wp_q;
      end
      if (pop) rp_d = ~rp_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      if (flush) begin
         wp_d  = 1'b0;
         rp_d  = 1'b0;
         cnt_d = 2'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
      mem_q <= mem_d;
   end
   assign dout  = mem_q[rp_q];
   assign full  = cnt_q == 2'd2;
   assign empty = cnt_q == 2'd0;
`else
   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   // push is only offered while empty, so push and pop never coincide
   always_comb begin
      data_d  = push ? din : data_q;
      valid_d = flush ? 1'b0 : push ? 1'b1 : pop ? 1'b0 : valid_q;
   end
   always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else valid_q <= valid_d;
      data_q <= data_d;
   end
   assign dout  = data_q;
   assign full  = valid_q;
   assign empty = ~valid_q;
`endif
endmodule

// File: rtl/front_end.sv
// front_end: pulls exactly size words from an FSL slave port and streams them to an actor.
// Define FRONT_END_SKID_EN for a 2-entry buffer (1 token/cycle); default is 1 token per 2 cycles.
module front_end
   import copr_stream_pkg::*;
#(
   parameter int SIZECOUNT = 12,
   parameter int SIZEDATA  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 FSL_S_READ,
   input  logic                 FSL_S_EXISTS,
   input  logic [SIZEDATA-1:0]  FSL_S_DATA,
   input  logic                 clear,
   input  logic [SIZECOUNT-1:0] size,
   output logic                 endrecv,
   output logic [SIZEDATA-1:0]  OUT_data,
   output logic                 OUT_send,
   input  logic                 OUT_ack,
   input  logic                 OUT_rdy
);
   stream_state_e        state_q, state_d;
   logic [SIZECOUNT-1:0] size_q, size_d, rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
   logic                 buf_full, buf_empty, pop;

   fe_skid_buf #(.W(SIZEDATA)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .flush (clear),
      .push  (FSL_S_READ),
      .pop   (pop),
      .din   (FSL_S_DATA),
      .dout  (OUT_data),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign FSL_S_READ = state_q == RUN && FSL_S_EXISTS && !buf_full && rd_cnt_q != size_q && !clear;
   assign OUT_send   = !buf_empty && OUT_rdy && !clear;
   assign pop        = OUT_send && OUT_ack;
   assign endrecv    = state_q == DONE;

   // clear wins over any read or ack in the same cycle
   always_comb begin
      state_d  = state_q;
      size_d   = size_q;
      rd_cnt_d = rd_cnt_q + SIZECOUNT'(FSL_S_READ);
      tx_cnt_d = tx_cnt_q + SIZECOUNT'(pop);
      if (state_q == RUN && tx_cnt_d == size_q) state_d = DONE;
      if (clear) begin
         size_d   = size;
         rd_cnt_d = '0;
         tx_cnt_d = '0;
         state_d  = size == '0 ? DONE : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         size_q   <= '0;
         rd_cnt_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         size_q   <= size_d;
         rd_cnt_q <= rd_cnt_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end
endmodule
